// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: memory-op codes, FSM states,
// big-endian byte-lane select patterns and op-class decode helpers.
package mem_stage_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Lane 0 is the most significant byte (big-endian).
  localparam logic [3:0] SEL_B0 = 4'b1000;
  localparam logic [3:0] SEL_B1 = 4'b0100;
  localparam logic [3:0] SEL_B2 = 4'b0010;
  localparam logic [3:0] SEL_B3 = 4'b0001;
  localparam logic [3:0] SEL_H0 = 4'b1100;
  localparam logic [3:0] SEL_H1 = 4'b0011;
  localparam logic [3:0] SEL_W  = 4'b1111;

  // Codes above OP_SW are reserved and behave as NOP.
  function automatic logic isMemOp(input logic [3:0] op);
    return (op != OP_NOP) && (op <= OP_SW);
  endfunction

  function automatic logic isLoadOp(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic for the MEM stage: bus byte enables, store data
// replication, load lane extraction with sign/zero extension, misalignment flag.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] loadData_o,
  output logic        misalign_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  assign byteLane = (addr_i == 2'b00) ? rdata_i[31:24] :
                    (addr_i == 2'b01) ? rdata_i[23:16] :
                    (addr_i == 2'b10) ? rdata_i[15:8]  : rdata_i[7:0];
  assign halfLane = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];

  always_comb begin
    sel_o      = 4'b0000;
    wdata_o    = reg2_i;
    loadData_o = rdata_i;
    misalign_o = 1'b0;
    case (op_i)
      OP_LB, OP_LBU, OP_SB: begin
        case (addr_i)
          2'b00:   sel_o = SEL_B0;
          2'b01:   sel_o = SEL_B1;
          2'b10:   sel_o = SEL_B2;
          default: sel_o = SEL_B3;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_o      = addr_i[1] ? SEL_H1 : SEL_H0;
        misalign_o = addr_i[0];
      end
      OP_LW, OP_SW: begin
        sel_o      = SEL_W;
        misalign_o = (addr_i != 2'b00);
      end
      default: ;
    endcase

    case (op_i)
      OP_SB:   wdata_o = {4{reg2_i[7:0]}};
      OP_SH:   wdata_o = {2{reg2_i[15:0]}};
      default: wdata_o = reg2_i;
    endcase

    case (op_i)
      OP_LB:   loadData_o = {{24{byteLane[7]}}, byteLane};
      OP_LBU:  loadData_o = {24'h000000, byteLane};
      OP_LH:   loadData_o = {{16{halfLane[15]}}, halfLane};
      OP_LHU:  loadData_o = {16'h0000, halfLane};
      default: loadData_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: write-back pass-through plus a req/ack data-bus handshake
// that stalls the pipeline for loads/stores. Optional bus timeout: MEM_BUS_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_wd,
  input  logic              mem_wreg,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_whilo,
  input  logic [31:0]       mem_hi,
  input  logic [31:0]       mem_lo,
  input  logic [3:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_reg2,
  output logic [4:0]        wb_wd,
  output logic              wb_wreg,
  output logic [31:0]       wb_wdata,
  output logic              wb_whilo,
  output logic [31:0]       wb_hi,
  output logic [31:0]       wb_lo,
  output logic              stallreq,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [31:0]       dbus_wdata,
  input  logic [31:0]       dbus_rdata,
  input  logic              dbus_ack,
  output logic              misalign,
  output logic              bus_err
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rstSeen_q;
  logic        memOp, loadOp, misalignRaw;
  logic [31:0] loadData;

  assign memOp  = isMemOp(mem_op);
  assign loadOp = isLoadOp(mem_op);

  mem_align u_align (
    .op_i       (mem_op),
    .addr_i     (mem_addr[1:0]),
    .reg2_i     (mem_reg2),
    .rdata_i    (rdata_q),
    .sel_o      (dbus_sel),
    .wdata_o    (dbus_wdata),
    .loadData_o (loadData),
    .misalign_o (misalignRaw)
  );

  assign dbus_addr = {mem_addr[ADDR_W-1:2], 2'b00};
  assign dbus_we   = memOp && !loadOp;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timedOut_q, timedOut_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      timedOut_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      timedOut_q <= timedOut_d;
    end
  end
`else
  // No timeout hardware: bus_err is constant low for any legal TIMEOUT_CYCLES.
  assign bus_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  // Suppresses a new request in the first cycle after reset even if EX/MEM still holds a memory op.
  always_ff @(posedge clk) begin
    rstSeen_q <= rst;
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    dbus_req = 1'b0;
    stallreq = 1'b0;
    misalign = 1'b0;
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    wb_whilo = mem_whilo;
    wb_hi    = mem_hi;
    wb_lo    = mem_lo;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
    timedOut_d = timedOut_q;
    bus_err    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (memOp && !rstSeen_q) begin
          if (misalignRaw) begin
            misalign = 1'b1;
            wb_wreg  = 1'b0;
          end else begin
            dbus_req = 1'b1;
            stallreq = 1'b1;
            wb_wreg  = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            timedOut_d = 1'b0;
            cnt_d      = '0;
`endif
            if (dbus_ack) begin
              rdata_d = dbus_rdata;
              state_d = ST_DONE;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        dbus_req = 1'b1;
        stallreq = 1'b1;
        wb_wreg  = 1'b0;
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          state_d = ST_DONE;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          timedOut_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (loadOp) begin
          wb_wdata = loadData;
        end else begin
          wb_wreg = 1'b0;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        if (timedOut_q) begin
          wb_wreg = 1'b0;
          bus_err = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected write-back and
// bus behaviour; a negedge monitor compares each completed instruction.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  memWd;
  logic        memWreg;
  logic [31:0] memWdata;
  logic        memWhilo;
  logic [31:0] memHi, memLo;
  logic [3:0]  memOp;
  logic [31:0] memAddr;
  logic [31:0] memReg2;
  logic [4:0]  wbWd;
  logic        wbWreg;
  logic [31:0] wbWdata;
  logic        wbWhilo;
  logic [31:0] wbHi, wbLo;
  logic        stallreq, dbusReq, dbusWe;
  logic [31:0] dbusAddr;
  logic [3:0]  dbusSel;
  logic [31:0] dbusWdata, dbusRdata;
  logic        dbusAck, misalign, busErr;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chkData;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        misal;
    logic        busErr;
    int          stalls;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] busW;
    logic [31:0] busAddr;
  } exp_t;

  exp_t expQ[$];

  mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wd     (memWd),
    .mem_wreg   (memWreg),
    .mem_wdata  (memWdata),
    .mem_whilo  (memWhilo),
    .mem_hi     (memHi),
    .mem_lo     (memLo),
    .mem_op     (memOp),
    .mem_addr   (memAddr),
    .mem_reg2   (memReg2),
    .wb_wd      (wbWd),
    .wb_wreg    (wbWreg),
    .wb_wdata   (wbWdata),
    .wb_whilo   (wbWhilo),
    .wb_hi      (wbHi),
    .wb_lo      (wbLo),
    .stallreq   (stallreq),
    .dbus_req   (dbusReq),
    .dbus_we    (dbusWe),
    .dbus_addr  (dbusAddr),
    .dbus_sel   (dbusSel),
    .dbus_wdata (dbusWdata),
    .dbus_rdata (dbusRdata),
    .dbus_ack   (dbusAck),
    .misalign   (misalign),
    .bus_err    (busErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts stall cycles, captures the first bus request, compares on completion.
  initial begin
    int          stallCnt;
    int          reqCnt;
    logic [3:0]  capSel;
    logic        capWe;
    logic [31:0] capW;
    logic [31:0] capAddr;
    exp_t        e;
    stallCnt = 0;
    reqCnt   = 0;
    capSel   = '0;
    capWe    = 1'b0;
    capW     = '0;
    capAddr  = '0;
    forever begin
      @(negedge clk);
      if (!rst && expQ.size() > 0) begin
        if (stallreq) begin
          if (stallCnt == 0) begin
            capSel  = dbusSel;
            capWe   = dbusWe;
            capW    = dbusWdata;
            capAddr = dbusAddr;
          end
          stallCnt++;
          if (dbusReq) reqCnt++;
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_wd", 32'(wbWd), 32'(e.wd));
          checkOutput("wb_wreg", 32'(wbWreg), 32'(e.wreg));
          if (e.chkData) checkOutput("wb_wdata", wbWdata, e.wdata);
          checkOutput("wb_whilo", 32'(wbWhilo), 32'(e.whilo));
          checkOutput("wb_hi", wbHi, e.hi);
          checkOutput("wb_lo", wbLo, e.lo);
          checkOutput("misalign", 32'(misalign), 32'(e.misal));
          checkOutput("bus_err", 32'(busErr), 32'(e.busErr));
          checkOutput("dbus_req_done", 32'(dbusReq), 32'd0);
          checkOutput("stall_cycles", 32'(stallCnt), 32'(e.stalls));
          checkOutput("req_cycles", 32'(reqCnt), 32'(e.stalls));
          if (e.stalls > 0) begin
            checkOutput("dbus_sel", 32'(capSel), 32'(e.sel));
            checkOutput("dbus_we", 32'(capWe), 32'(e.we));
            checkOutput("dbus_addr", capAddr, e.busAddr);
            if (e.we) checkOutput("dbus_wdata", capW, e.busW);
          end
          stallCnt = 0;
          reqCnt   = 0;
        end
      end
    end
  end

  // ackDelay: request cycle in which ack is driven (1 = immediate, 0 = never).
  task automatic applyStimulus(
    input logic [3:0]  op,
    input logic [31:0] addr,
    input logic [31:0] reg2,
    input logic [31:0] alu,
    input logic [31:0] rdata,
    input int          ackDelay,
    input logic [31:0] expData,
    input logic        expWreg,
    input logic        chkData,
    input int          expStalls,
    input logic [3:0]  expSel,
    input logic        expWe,
    input logic [31:0] expBusW,
    input logic        expMisal,
    input logic        expBusErr
  );
    exp_t e;
    bit   done;
    @(posedge clk);
    #1;
    memOp    = op;
    memAddr  = addr;
    memReg2  = reg2;
    memWdata = alu;
    memWreg  = 1'b1;
    memWd    = {1'b0, op} + 5'd1;
    memWhilo = op[0];
    memHi    = ~alu;
    memLo    = alu ^ 32'h5A5A5A5A;
    e.wd      = {1'b0, op} + 5'd1;
    e.wreg    = expWreg;
    e.wdata   = expData;
    e.chkData = chkData;
    e.whilo   = op[0];
    e.hi      = ~alu;
    e.lo      = alu ^ 32'h5A5A5A5A;
    e.misal   = expMisal;
    e.busErr  = expBusErr;
    e.stalls  = expStalls;
    e.sel     = expSel;
    e.we      = expWe;
    e.busW    = expBusW;
    e.busAddr = {addr[31:2], 2'b00};
    expQ.push_back(e);
    done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      dbusAck   = (ackDelay == cyc);
      dbusRdata = dbusAck ? rdata : 32'h0BAD0BAD;
      @(negedge clk);
      if (!stallreq) done = 1'b1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL completion_timeout: op %0d still stalled after 40 cycles, required completion", op);
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    memOp     = 4'd0;
    memAddr   = '0;
    memReg2   = '0;
    memWdata  = 32'h0F0F0F0F;
    memWreg   = 1'b1;
    memWd     = 5'd7;
    memWhilo  = 1'b0;
    memHi     = '0;
    memLo     = '0;
    dbusAck   = 1'b0;
    dbusRdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_dbus_req", 32'(dbusReq), 32'd0);
    checkOutput("reset_stallreq", 32'(stallreq), 32'd0);
    checkOutput("reset_misalign", 32'(misalign), 32'd0);
    checkOutput("reset_bus_err", 32'(busErr), 32'd0);
    checkOutput("reset_wb_wdata", wbWdata, 32'h0F0F0F0F);
    @(posedge clk);
    #1 rst = 1'b0;

    //            op     addr          reg2          alu           rdata         ack  expData       wreg chk stl sel      we    busW          mis  berr
    applyStimulus(4'd0,  32'h00000000, 32'h0,        32'h12345678, 32'h0,        0,   32'h12345678, 1'b1, 1'b1, 0, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0);
    applyStimulus(4'd1,  32'h00001001, 32'h0,        32'h00001001, 32'h11F23344, 3,   32'hFFFFFFF2, 1'b1, 1'b1, 3, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b0);
    applyStimulus(4'd2,  32'h00001001, 32'h0,        32'h00001001, 32'h11F23344, 3,   32'h000000F2, 1'b1, 1'b1, 3, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b0);
    applyStimulus(4'd7,  32'h00002002, 32'hAAAABEEF, 32'h00002002, 32'h0,        1,   32'h00002002, 1'b0, 1'b1, 1, 4'b0011, 1'b1, 32'hBEEFBEEF, 1'b0, 1'b0);
    applyStimulus(4'd5,  32'h00003001, 32'h0,        32'h00003001, 32'h0,        0,   32'h00003001, 1'b0, 1'b1, 0, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0);
    applyStimulus(4'd3,  32'h00001002, 32'h0,        32'h00001002, 32'h11F28344, 2,   32'hFFFF8344, 1'b1, 1'b1, 2, 4'b0011, 1'b0, 32'h0,        1'b0, 1'b0);
    applyStimulus(4'd4,  32'h00001000, 32'h0,        32'h00001000, 32'h80017FFF, 1,   32'h00008001, 1'b1, 1'b1, 1, 4'b1100, 1'b0, 32'h0,        1'b0, 1'b0);
    applyStimulus(4'd5,  32'h00001004, 32'h0,        32'h00001004, 32'hDEADBEEF, 1,   32'hDEADBEEF, 1'b1, 1'b1, 1, 4'b1111, 1'b0, 32'h0,        1'b0, 1'b0);
    applyStimulus(4'd6,  32'h00002003, 32'h123456A5, 32'h00002003, 32'h0,        2,   32'h00002003, 1'b0, 1'b1, 2, 4'b0001, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    applyStimulus(4'd8,  32'h00002008, 32'hCAFEF00D, 32'h00002008, 32'h0,        1,   32'h00002008, 1'b0, 1'b1, 1, 4'b1111, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    applyStimulus(4'd1,  32'h00001000, 32'h0,        32'h00001000, 32'h7F000000, 1,   32'h0000007F, 1'b1, 1'b1, 1, 4'b1000, 1'b0, 32'h0,        1'b0, 1'b0);
    applyStimulus(4'd3,  32'h00001003, 32'h0,        32'h00001003, 32'h0,        0,   32'h00001003, 1'b0, 1'b1, 0, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0);
    applyStimulus(4'd12, 32'h00001003, 32'h0,        32'hA5A50001, 32'h0,        0,   32'hA5A50001, 1'b1, 1'b1, 0, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0);

    // Reset while waiting for an ack; a late ack afterwards must not start or finish anything.
    @(posedge clk);
    #1;
    memOp   = 4'd5;
    memAddr = 32'h00004000;
    dbusAck = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_req_idle", 32'(dbusReq), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("pre_reset_stall_wait", 32'(stallreq), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    dbusAck   = 1'b1;
    dbusRdata = 32'h55555555;
    @(negedge clk);
    checkOutput("post_reset_dbus_req", 32'(dbusReq), 32'd0);
    checkOutput("post_reset_stallreq", 32'(stallreq), 32'd0);
    checkOutput("post_reset_misalign", 32'(misalign), 32'd0);
    @(posedge clk);
    #1;
    memOp    = 4'd0;
    memWdata = 32'h0000ABCD;
    memWreg  = 1'b1;
    @(negedge clk);
    checkOutput("late_ack_stallreq", 32'(stallreq), 32'd0);
    checkOutput("late_ack_dbus_req", 32'(dbusReq), 32'd0);
    checkOutput("late_ack_wb_wdata", wbWdata, 32'h0000ABCD);
    checkOutput("late_ack_wb_wreg", 32'(wbWreg), 32'd1);
    @(posedge clk);
    #1 dbusAck = 1'b0;

    applyStimulus(4'd5,  32'h00004000, 32'h0,        32'h00004000, 32'h13579BDF, 2,   32'h13579BDF, 1'b1, 1'b1, 2, 4'b1111, 1'b0, 32'h0,        1'b0, 1'b0);

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: one IDLE cycle plus four WAIT cycles, then DONE with bus_err.
    applyStimulus(4'd5,  32'h00005000, 32'h0,        32'h00005000, 32'h0,        0,   32'h0,        1'b0, 1'b0, 5, 4'b1111, 1'b0, 32'h0,        1'b0, 1'b1);
`endif

    @(posedge clk);
    @(posedge clk);
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage. Sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Passes register-file and HI/LO write-back information through unchanged for non-memory instructions.
- For loads and stores, runs a data-bus request/acknowledge handshake and holds the pipeline with a stall request until the access completes.
- Handles byte-lane selection and load sign/zero extension. Byte order is big-endian.

Parameters:
- ADDR_W, 32, data-bus address width.
- TIMEOUT_CYCLES, 255, maximum wait for dbus_ack; used only when MEM_BUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_wd  in  5  destination register
- mem_wreg  in  1  register-write enable
- mem_wdata  in  32  ALU result
- mem_whilo  in  1  HI/LO write enable
- mem_hi  in  32  HI value
- mem_lo  in  32  LO value
- mem_op  in  4  memory-op code (package constants)
- mem_addr  in  ADDR_W  effective address
- mem_reg2  in  32  store source data
- wb_wd  out  5  destination register to MEM/WB
- wb_wreg  out  1  register-write enable to MEM/WB
- wb_wdata  out  32  write-back data to MEM/WB
- wb_whilo  out  1  HI/LO write enable to MEM/WB
- wb_hi  out  32  HI value to MEM/WB
- wb_lo  out  32  LO value to MEM/WB
- stallreq  out  1  freeze request to pipeline control
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write enable
- dbus_addr  out  ADDR_W  word-aligned bus address ({addr[ADDR_W-1:2],2'b00})
- dbus_sel  out  4  byte enables
- dbus_wdata  out  32  bus write data
- dbus_rdata  in  32  bus read data
- dbus_ack  in  1  bus completion
- misalign  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on bus timeout (feature only)

Behaviour:
- mem_op codes: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8. Codes 9–15 are treated as NOP.
- Non-memory op:
  - wb_* equal the mem_* inputs combinationally.
  - stallreq=0; dbus_req=0.
- FSM states:
  - IDLE: on a mem op that is aligned, drive dbus_req=1 and stallreq=1. If dbus_ack is sampled high in the same cycle, go to DONE; otherwise go to WAIT.
  - WAIT: dbus_req=1 and stallreq=1. On dbus_ack, capture dbus_rdata into rdata_q and go to DONE.
  - DONE: dbus_req=0 and stallreq=0. wb_* are valid for this cycle only; the pipeline advances at the end of the cycle. Next state is IDLE.
- Latency: a memory op takes a minimum of 2 cycles, and 1+N cycles for an ack arriving N cycles after the request.
- The stall freezes EX/MEM, so the mem_* inputs are stable from IDLE through DONE.
- dbus_addr, dbus_we, dbus_sel and dbus_wdata are held constant while dbus_req=1.
- dbus_ack is ignored in IDLE when no request is issued, and ignored in DONE.
- Byte lanes (big-endian):
  - Byte access: addr[1:0]=00 → sel 1000, 01 → 0100, 10 → 0010, 11 → 0001.
  - Halfword access: addr[1]=0 → sel 1100, addr[1]=1 → 0011.
  - Word access: sel 1111.
  - Loads drive the same sel pattern as stores.
- Store data:
  - SB replicates reg2[7:0] into all four byte lanes.
  - SH replicates reg2[15:0] into both halfword lanes.
  - SW passes reg2 unchanged.
- Load result in DONE:
  - wb_wdata = the selected lane of rdata_q. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
  - wb_wreg = mem_wreg.
- Stores:
  - wb_wreg = 0 in DONE.
  - HI/LO write-back is not affected.
- Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0):
  - No bus request and no stall.
  - wb_wreg=0 and misalign=1 for that cycle.
- Reset (also mid-operation):
  - state=IDLE, rdata_q=0.
  - dbus_req, stallreq, misalign and bus_err are 0 in the cycle after rst is sampled.
  - wb_* revert to the combinational pass-through.

Optional Feature:
- MEM_BUS_TIMEOUT_EN defined:
  - An 8-bit+ counter runs while in WAIT.
  - When the counter reaches TIMEOUT_CYCLES without dbus_ack: drop dbus_req, pulse bus_err=1 for one cycle, go to DONE with wb_wreg=0.
  - The counter clears on entry to WAIT and on reset.
- MEM_BUS_TIMEOUT_EN undefined:
  - WAIT holds indefinitely.
  - bus_err is tied to 0.
  - No counter logic is generated.

Decomposition:
- Shared package holds the mem_op code constants, FSM state encodings (IDLE/WAIT/DONE) and byte-lane sel constants.
- Sub-module mem_align (combinational): generates sel and wdata from op/addr/reg2, performs load extraction/extension from rdata_q, and produces the misalign flag.
- The FSM and counter stay in mem_stage.

Test Plan:
- ADD result passthrough: mem_op=0, mem_wdata=0x12345678, mem_wreg=1 → wb_wdata=0x12345678 the same cycle, stallreq=0, dbus_req=0.
- LB with a 3-cycle ack delay: addr=0x1001, rdata=0x11F23344 → sel=0100, stallreq high 3 cycles, DONE wb_wdata=0xFFFFFFF2; LBU gives 0x000000F2.
- SH at addr 0x2002, reg2=0xAAAABEEF, immediate ack → dbus_we=1, sel=0011, wdata=0xBEEFBEEF, wb_wreg=0, total 2 cycles.
- LW at addr 0x3001 → no dbus_req, misalign=1 for one cycle, wb_wreg=0, stallreq=0.
- rst asserted in WAIT → the next cycle has state IDLE, dbus_req=0, stallreq=0; a late ack is ignored.
- MEM_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack → bus_err pulse after 4 WAIT cycles, stall released in DONE, wb_wreg=0.
